ct_butterfly: RTL
=================

CT_BUTTERFLY -- requirements
Module: ct_butterfly

Interface
REQ-001 The block SHALL have parameter Q, default 998244353, the prime modulus; it must be odd, >2 and <2^30.
REQ-002 The block SHALL have parameter LAT, default 5, the fixed input-to-output latency in advancing cycles; it is informational and must not be overridden.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: A, B and w carry a valid operand set.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts an operand set this cycle.
REQ-007 The block SHALL have port A, input, 30 bits: upper operand, 0 <= A < Q.
REQ-008 The block SHALL have port B, input, 30 bits: lower operand, 0 <= B < Q.
REQ-009 The block SHALL have port w, input, 30 bits: twiddle factor, 0 <= w < Q.
REQ-010 The block SHALL have port out_valid, output, 1 bit: a and b carry a valid result.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the downstream stage accepts the result.
REQ-012 The block SHALL have port a, output, 30 bits: (A + w*B) mod Q.
REQ-013 The block SHALL have port b, output, 30 bits: (A - w*B) mod Q.

Function
REQ-014 The block SHALL implement the forward (Cooley-Tukey) butterfly: t = w*B mod Q; a = (A + t) mod Q; b = (A - t) mod Q; a and b are always in [0, Q-1].
REQ-015 The block SHALL be a 5-stage pipeline:
- S1 registers the full 60-bit product w*B together with A.
- S2-S4 perform the modular reduction of the product to t < Q (Barrett or equivalent, exact, no final result >= Q).
- S5 registers the modular add and subtract.
- A and valid are carried alongside every stage.
REQ-016 The block SHALL form the add as A+t, subtracting Q if the sum is >= Q, and the subtract as A-t, adding Q if negative; 31-bit intermediates, no lost carry.
REQ-017 The block SHALL define stall = out_valid AND NOT out_ready; when stall=1, every pipeline register, valid bit included, holds its value.
REQ-018 The block SHALL drive in_ready = NOT stall, combinationally.
REQ-019 The block SHALL accept an operand set only on a cycle with in_valid=1 and in_ready=1; when in_ready=1 and in_valid=0, a bubble (valid=0) enters S1.
REQ-020 The block SHALL retire a result only on a cycle with out_valid=1 and out_ready=1.
REQ-021 The block SHALL, with no stall, present the result of an operand set accepted at edge k at edge k+5, giving a throughput of one set per cycle.
REQ-022 The block SHALL deliver results strictly in acceptance order, with none dropped or duplicated under any out_ready pattern.
REQ-023 The block SHALL treat in_valid=1 while in_ready=0 as no transfer; the source must hold its inputs, and the block must not sample them.
REQ-024 The block SHALL keep a and b stable while out_valid=1 and out_ready=0.
REQ-025 The block SHALL treat operands >= Q as outside the contract; only out_valid timing is then guaranteed, and a and b are unspecified.
REQ-026 The block SHALL handle the boundary w=0 as a=b=A, B=0 as a=b=A, and A=0 with t=0 as a=b=0, with no special-case path.

Reset
REQ-027 The block SHALL, while rst_n=0, asynchronously clear all valid bits, so out_valid=0 and in_ready=1 immediately.
REQ-028 The block SHALL, while rst_n=0, clear a and b to 0; datapath registers other than valid bits, a and b need not be reset.
REQ-029 The block SHALL, on reset assertion mid-operation, discard all in-flight sets; the first set accepted after deassertion appears exactly 5 advancing cycles later.

Verification (Q=998244353)
REQ-030 The bench SHALL cover: A=5, B=3, w=2, out_ready=1 -> 5 cycles later out_valid=1, a=11, b=998244352.
REQ-031 The bench SHALL cover: A=0, B=1, w=998244352 -> a=998244352, b=1; then A=B=w=998244352 -> a=0, b=998244351.
REQ-032 The bench SHALL cover: 8 back-to-back sets with out_ready=1 -> 8 consecutive out_valid cycles, in order, and values matching a reference model.
REQ-033 The bench SHALL cover: 20 random sets with out_ready toggled pseudo-randomly -> in_ready = NOT(out_valid AND NOT out_ready) every cycle, held outputs stable, and no loss, duplication or reordering.
REQ-034 The bench SHALL cover: rst_n pulsed low with 3 sets in flight -> out_valid=0 and a=b=0 at once; the next set emerges after exactly 5 cycles.
REQ-035 The bench SHALL cover: w=0, A=123, B=456 -> a=b=123; and w=1, A=B=Q-1 -> a=Q-2, b=0.

Source files
------------

// File: rtl/ct_butterfly.sv
// Forward Cooley-Tukey NTT butterfly: a = A + w*B, b = A - w*B (mod Q).
// Five-stage pipeline with valid/ready flow control and a whole-pipe stall.
module ct_butterfly #(
    parameter int unsigned Q   = 998244353,
    parameter int unsigned LAT = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [29:0] A,
    input  logic [29:0] B,
    input  logic [29:0] w,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [29:0] a,
    output logic [29:0] b
);

    if (Q < 3 || Q >= (32'd1 << 30) || (Q % 2) == 0 || LAT != 5) begin : g_bad_param
        $error("ct_butterfly: Q must be odd with 2 < Q < 2^30, and LAT must stay 5");
    end

    // Barrett constants: K is the bit length of Q, so 2^(K-1) < Q < 2^K.
    localparam int unsigned K   = $clog2(Q);
    localparam logic [31:0] MU  = 32'((64'd1 << (2 * K)) / 64'(Q));
    localparam logic [29:0] Q30 = 30'(Q);
    localparam logic [30:0] Q31 = 31'(Q);
    localparam logic [31:0] Q32 = 32'(Q);
    localparam logic [59:0] Q60 = 60'(Q);

    logic       stall;
    logic       advance;
    logic [4:0] vld;

    logic [59:0] s1_p;
    logic [29:0] s1_a;
    logic [59:0] s2_p;
    logic [29:0] s2_q;
    logic [29:0] s2_a;
    logic [31:0] s3_r;
    logic [29:0] s3_a;
    logic [29:0] s4_t;
    logic [29:0] s4_a;

    logic [91:0] q_prod;
    logic [29:0] q_est;
    logic [59:0] qm;
    logic [59:0] r_full;
    logic [31:0] r_next;
    logic [31:0] red;
    logic [29:0] t_next;
    logic [30:0] sum;
    logic [30:0] dif;
    logic [30:0] a_wide;
    logic [30:0] b_wide;

    assign out_valid = vld[4];
    assign stall     = vld[4] & ~out_ready;
    assign advance   = ~stall;
    assign in_ready  = advance;

    // Quotient estimate q3 = ((x >> (K-1)) * MU) >> (K+1); it undershoots by at most 2.
    always_comb begin
        q_prod = 92'(s1_p >> (K - 1)) * 92'(MU);
        q_est  = 30'(q_prod >> (K + 1));
    end

    // Remainder x - q3*Q lies in [0, 3Q), which fits in 32 bits for Q < 2^30.
    always_comb begin
        qm     = 60'(s2_q) * Q60;
        r_full = s2_p - qm;
        r_next = 32'(r_full);
    end

    always_comb begin
        red = s3_r;
        if (red >= Q32) begin
            red = red - Q32;
        end
        if (red >= Q32) begin
            red = red - Q32;
        end
        t_next = 30'(red);
    end

    always_comb begin
        sum    = {1'b0, s4_a} + {1'b0, s4_t};
        dif    = {1'b0, s4_a} - {1'b0, s4_t};
        a_wide = (sum >= Q31) ? (sum - Q31) : sum;
        b_wide = dif[30] ? (dif + Q31) : dif;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
        end else if (advance) begin
            vld <= {vld[3:0], in_valid};
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            s1_p <= 60'(w) * 60'(B);
            s1_a <= A;
            s2_p <= s1_p;
            s2_q <= q_est;
            s2_a <= s1_a;
            s3_r <= r_next;
            s3_a <= s2_a;
            s4_t <= t_next;
            s4_a <= s3_a;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a <= '0;
            b <= '0;
        end else if (advance) begin
            a <= 30'(a_wide);
            b <= 30'(b_wide);
        end
    end

    logic unused_q30;
    assign unused_q30 = ^Q30;

endmodule
